// File: rtl/fpu_issue_ctrl_if.sv
// CPU-side request/response channel of the FPU issue controller.
// The CPU drives the master modport and the controller uses the slave modport.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_rd;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_y;
  logic [TAG_W-1:0] rsp_rd;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_rd, req_x1, req_x2, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_x1, req_x2, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_rd, rsp_err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/response controller between the CPU execute stage and the FPU: one request
// in flight, one-hot opcode pulse, watchdog timeout and sticky exception flags.
module fpu_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic            sys_clk,
  input  logic            rstn,
  fpu_issue_ctrl_if.slave cpu,
  output logic [7:0]      fpu_opcode,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  input  logic [31:0]     fpu_y,
  input  logic            fpu_valid,
  input  logic            fpu_ovf,
  input  logic            fpu_unf,
  output logic            flags_ovf,
  output logic            flags_unf,
  input  logic            flags_clr
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wdog_cnt;
  logic [TAG_W-1:0] rd_q;
  logic [31:0]      rsp_y_q;
  logic [TAG_W-1:0] rsp_rd_q;
  logic             rsp_err_q;
  logic             accept;
  logic             capture;
  logic             expire;

  // NOTE: rstn is synchronous, so it is tested inside the clocked block and kept
  // out of the sensitivity list; registers use <= so they all see pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu.req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A result arriving on the last watchdog cycle still counts as success.
        if (fpu_valid) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (wdog_cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (cpu.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      fpu_opcode <= '0;
      fpu_x1     <= '0;
      fpu_x2     <= '0;
      rd_q       <= '0;
      wdog_cnt   <= '0;
      rsp_y_q    <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= 1'b0;
      flags_ovf  <= 1'b0;
      flags_unf  <= 1'b0;
    end else begin
      // The opcode is only ever loaded on acceptance, so it is one-hot for the ISSUE cycle alone.
      fpu_opcode <= accept ? (8'b1 << cpu.req_op) : 8'h00;
      if (accept) begin
        fpu_x1 <= cpu.req_x1;
        fpu_x2 <= cpu.req_x2;
        rd_q   <= cpu.req_rd;
      end

      if (state == ISSUE)     wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + CNT_W'(1);

      if (capture) begin
        rsp_y_q   <= fpu_y;
        rsp_rd_q  <= rd_q;
        rsp_err_q <= 1'b0;
      end else if (expire) begin
        rsp_y_q   <= '0;
        rsp_rd_q  <= rd_q;
        rsp_err_q <= 1'b1;
      end

      // A capture in the same cycle as a clear leaves the flag set.
      flags_ovf <= (flags_ovf & ~flags_clr) | (capture & fpu_ovf);
      flags_unf <= (flags_unf & ~flags_clr) | (capture & fpu_unf);
    end
  end

  assign cpu.req_ready = (state == IDLE) && rstn;
  assign cpu.rsp_valid = (state == RESP);
  assign cpu.rsp_y     = rsp_y_q;
  assign cpu.rsp_rd    = rsp_rd_q;
  assign cpu.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: scripted FPU model, response scoreboard and
// per-feature scenario tasks (latency, flags, watchdog, backpressure, reset).
module tb_fpu_issue_ctrl;

  localparam int TIMEOUT = 8;
  localparam int TAG_W   = 5;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] rd;
    logic             err;
  } rsp_t;

  logic        sys_clk   = 1'b0;
  logic        rstn      = 1'b0;
  logic [7:0]  fpu_opcode;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic [31:0] fpu_y     = '0;
  logic        fpu_valid = 1'b0;
  logic        fpu_ovf   = 1'b0;
  logic        fpu_unf   = 1'b0;
  logic        flags_ovf;
  logic        flags_unf;
  logic        tb_clr    = 1'b0;
  logic        m_clr     = 1'b0;
  logic        flags_clr;

  assign flags_clr = tb_clr | m_clr;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) cpu ();

  fpu_issue_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .cpu        (cpu),
    .fpu_opcode (fpu_opcode),
    .fpu_x1     (fpu_x1),
    .fpu_x2     (fpu_x2),
    .fpu_y      (fpu_y),
    .fpu_valid  (fpu_valid),
    .fpu_ovf    (fpu_ovf),
    .fpu_unf    (fpu_unf),
    .flags_ovf  (flags_ovf),
    .flags_unf  (flags_unf),
    .flags_clr  (flags_clr)
  );

  always #5 sys_clk = ~sys_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];

  // FPU model configuration, written only by the scenario tasks.
  bit          m_en           = 1'b0;
  int          m_lat          = 1;
  logic [31:0] m_y            = '0;
  bit          m_ovf          = 1'b0;
  bit          m_unf          = 1'b0;
  bit          m_clr_on_valid = 1'b0;
  bit          m_armed        = 1'b0;
  int          m_wait         = 0;

  // FPU stub: m_lat = k raises fpu_valid in the k-th WAIT cycle after the opcode pulse.
  always @(negedge sys_clk) begin
    fpu_valid = 1'b0;
    fpu_ovf   = 1'b0;
    fpu_unf   = 1'b0;
    m_clr     = 1'b0;
    if (!rstn) begin
      m_armed = 1'b0;
    end else if (m_armed) begin
      if (m_wait == 0) begin
        fpu_valid = 1'b1;
        fpu_y     = m_y;
        fpu_ovf   = m_ovf;
        fpu_unf   = m_unf;
        m_clr     = m_clr_on_valid;
        m_armed   = 1'b0;
      end else begin
        m_wait--;
      end
    end
    if (rstn && m_en && fpu_opcode != 8'h00) begin
      m_armed = 1'b1;
      m_wait  = m_lat - 1;
    end
  end

  // Scoreboard: every completed response handshake pops one expected entry.
  always @(negedge sys_clk) begin
    if (rstn && cpu.rsp_valid && cpu.rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got y=%h rd=%0d err=%0b with no request outstanding",
                 cpu.rsp_y, cpu.rsp_rd, cpu.rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (cpu.rsp_y !== e.y) begin
          n_fail++;
          $display("FAIL rsp_y: got %h expected %h", cpu.rsp_y, e.y);
        end
        n_checks++;
        if (cpu.rsp_rd !== e.rd) begin
          n_fail++;
          $display("FAIL rsp_rd: got %0d expected %0d", cpu.rsp_rd, e.rd);
        end
        n_checks++;
        if (cpu.rsp_err !== e.err) begin
          n_fail++;
          $display("FAIL rsp_err: got %0b expected %0b", cpu.rsp_err, e.err);
        end
      end
    end
  end

  function automatic rsp_t mk(input logic [31:0] y, input logic [TAG_W-1:0] rd, input logic err);
    rsp_t r;
    r.y   = y;
    r.rd  = rd;
    r.err = err;
    return r;
  endfunction

  task automatic set_fpu(input bit en, input int lat, input logic [31:0] y,
                         input bit ovf, input bit unf);
    m_en  = en;
    m_lat = lat;
    m_y   = y;
    m_ovf = ovf;
    m_unf = unf;
  endtask

  // Drives one request; returns in cycle 1 (the ISSUE cycle) just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [TAG_W-1:0] rd,
                      input logic [31:0] x1, input logic [31:0] x2, output bit ok);
    @(posedge sys_clk);
    #1;
    cpu.req_valid = 1'b1;
    cpu.req_op    = op;
    cpu.req_rd    = rd;
    cpu.req_x1    = x1;
    cpu.req_x2    = x2;
    ok = 1'b0;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge sys_clk);
      ok = cpu.req_ready;
      @(posedge sys_clk);
      #1;
    end
    cpu.req_valid = 1'b0;
  endtask

  // Called at the negedge of cycle 'start'; returns at the negedge of the first rsp_valid cycle.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!cpu.rsp_valid && lat < 64) begin
      @(negedge sys_clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if (cpu.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %0b expected 0", cpu.req_ready);
    end
    n_checks++;
    if ({fpu_opcode, fpu_x1, fpu_x2, cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd, cpu.rsp_err,
         flags_ovf, flags_unf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got op=%h x1=%h x2=%h rv=%b y=%h rd=%h err=%b flags=%b%b expected all 0",
               fpu_opcode, fpu_x1, fpu_x2, cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd, cpu.rsp_err,
               flags_ovf, flags_unf);
    end
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (cpu.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_req_ready: got %0b expected 1", cpu.req_ready);
    end
  endtask

  task automatic test_fadd();
    int lat;
    bit ok;
    set_fpu(1'b1, 2, 32'h4040_0000, 1'b0, 1'b0);
    exp_q.push_back(mk(32'h4040_0000, 5'd3, 1'b0));
    send(3'd0, 5'd3, 32'h3F80_0000, 32'h4000_0000, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL fadd_accept: got %0b expected 1", ok);
    end
    @(negedge sys_clk);
    n_checks++;
    if (fpu_opcode !== 8'h01) begin
      n_fail++;
      $display("FAIL fadd_opcode: got %h expected 01", fpu_opcode);
    end
    n_checks++;
    if ({fpu_x1, fpu_x2} !== {32'h3F80_0000, 32'h4000_0000}) begin
      n_fail++;
      $display("FAIL fadd_operands: got %h/%h expected 3f800000/40000000", fpu_x1, fpu_x2);
    end
    @(negedge sys_clk);
    n_checks++;
    if (fpu_opcode !== 8'h00) begin
      n_fail++;
      $display("FAIL fadd_pulse_width: got %h in WAIT expected 00", fpu_opcode);
    end
    wait_rsp(2, lat);
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL fadd_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if ({flags_ovf, flags_unf} !== 2'b00) begin
      n_fail++;
      $display("FAIL fadd_flags: got %b%b expected 00", flags_ovf, flags_unf);
    end
  endtask

  task automatic test_fabs_latency();
    int lat;
    bit ok;
    set_fpu(1'b1, 1, 32'h3F80_0000, 1'b0, 1'b0);
    exp_q.push_back(mk(32'h3F80_0000, 5'd7, 1'b0));
    send(3'd7, 5'd7, 32'hBF80_0000, 32'h0000_0000, ok);
    @(negedge sys_clk);
    n_checks++;
    if (fpu_opcode !== 8'h80) begin
      n_fail++;
      $display("FAIL fabs_opcode: got %h expected 80", fpu_opcode);
    end
    wait_rsp(1, lat);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL fabs_min_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [TAG_W-1:0] rd,
                        input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] y,
                        input bit ovf, input bit unf);
    int lat;
    bit ok;
    set_fpu(1'b1, 2, y, ovf, unf);
    exp_q.push_back(mk(y, rd, 1'b0));
    send(op, rd, x1, x2, ok);
    @(negedge sys_clk);
    wait_rsp(1, lat);
  endtask

  task automatic test_flags();
    run_op(3'd2, 5'd4, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
    n_checks++;
    if ({flags_ovf, flags_unf} !== 2'b10) begin
      n_fail++;
      $display("FAIL flags_ovf_set: got %b%b expected 10", flags_ovf, flags_unf);
    end
    run_op(3'd0, 5'd5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    n_checks++;
    if (flags_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_ovf_sticky: got %b expected 1", flags_ovf);
    end
    run_op(3'd3, 5'd6, 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1);
    n_checks++;
    if ({flags_ovf, flags_unf} !== 2'b11) begin
      n_fail++;
      $display("FAIL flags_unf_set: got %b%b expected 11", flags_ovf, flags_unf);
    end
    @(posedge sys_clk);
    #1;
    tb_clr = 1'b1;
    @(posedge sys_clk);
    #1;
    tb_clr = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if ({flags_ovf, flags_unf} !== 2'b00) begin
      n_fail++;
      $display("FAIL flags_clear: got %b%b expected 00", flags_ovf, flags_unf);
    end
    m_clr_on_valid = 1'b1;
    run_op(3'd2, 5'd8, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
    m_clr_on_valid = 1'b0;
    n_checks++;
    if (flags_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_set_beats_clear: got %b expected 1", flags_ovf);
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit ok;
    set_fpu(1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    exp_q.push_back(mk(32'h0000_0000, 5'd9, 1'b1));
    send(3'd3, 5'd9, 32'h3F80_0000, 32'h0000_0000, ok);
    @(negedge sys_clk);
    wait_rsp(1, lat);
    n_checks++;
    if (lat != TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 2);
    end
    n_checks++;
    if (flags_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flags_unchanged: got %b expected 1", flags_ovf);
    end
    set_fpu(1'b1, TIMEOUT, 32'h1234_5678, 1'b0, 1'b0);
    exp_q.push_back(mk(32'h1234_5678, 5'd10, 1'b0));
    send(3'd4, 5'd10, 32'h4080_0000, 32'h0000_0000, ok);
    @(negedge sys_clk);
    wait_rsp(1, lat);
    n_checks++;
    if (lat != TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL valid_on_last_wait_latency: got %0d expected %0d", lat, TIMEOUT + 2);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    set_fpu(1'b1, 1, 32'hC000_0000, 1'b0, 1'b0);
    exp_q.push_back(mk(32'hC000_0000, 5'd17, 1'b0));
    send(3'd1, 5'd17, 32'h3F80_0000, 32'h4040_0000, ok);
    cpu.rsp_ready = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (fpu_opcode !== 8'h02) begin
      n_fail++;
      $display("FAIL fsub_opcode: got %h expected 02", fpu_opcode);
    end
    wait_rsp(1, lat);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL fsub_latency: got %0d expected 3", lat);
    end
    set_fpu(1'b1, 1, 32'h40C0_0000, 1'b0, 1'b0);
    exp_q.push_back(mk(32'h40C0_0000, 5'd18, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 0) begin
        cpu.req_valid = 1'b1;
        cpu.req_op    = 3'd2;
        cpu.req_rd    = 5'd18;
        cpu.req_x1    = 32'h4000_0000;
        cpu.req_x2    = 32'h4040_0000;
      end
      @(negedge sys_clk);
      n_checks++;
      if ({cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd} !== {1'b1, 32'hC000_0000, 5'd17}) begin
        n_fail++;
        $display("FAIL hold_rsp[%0d]: got v=%b y=%h rd=%0d expected v=1 y=c0000000 rd=17",
                 i, cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd);
      end
      n_checks++;
      if (cpu.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, cpu.req_ready);
      end
      n_checks++;
      if ({fpu_opcode, fpu_x1} !== {8'h00, 32'h3F80_0000}) begin
        n_fail++;
        $display("FAIL hold_no_accept[%0d]: got op=%h x1=%h expected op=00 x1=3f800000",
                 i, fpu_opcode, fpu_x1);
      end
    end
    @(posedge sys_clk);
    #1;
    cpu.rsp_ready = 1'b1;
    @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    n_checks++;
    if ({cpu.req_ready, cpu.rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL after_handshake: got ready=%b rsp_valid=%b expected ready=1 rsp_valid=0",
               cpu.req_ready, cpu.rsp_valid);
    end
    @(posedge sys_clk);
    #1;
    cpu.req_valid = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if ({fpu_opcode, fpu_x1} !== {8'h04, 32'h4000_0000}) begin
      n_fail++;
      $display("FAIL second_accept: got op=%h x1=%h expected op=04 x1=40000000", fpu_opcode, fpu_x1);
    end
    wait_rsp(1, lat);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL second_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    set_fpu(1'b0, 1, 32'h0000_0000, 1'b0, 1'b0);
    send(3'd0, 5'd21, 32'h3F80_0000, 32'h3F80_0000, ok);
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    rstn = 1'b0;
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (cpu.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_req_ready: got %b expected 1", cpu.req_ready);
    end
    n_checks++;
    if ({fpu_opcode, fpu_x1, fpu_x2, cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd, cpu.rsp_err,
         flags_ovf, flags_unf} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got op=%h x1=%h x2=%h rv=%b y=%h rd=%h err=%b flags=%b%b expected all 0",
               fpu_opcode, fpu_x1, fpu_x2, cpu.rsp_valid, cpu.rsp_y, cpu.rsp_rd, cpu.rsp_err,
               flags_ovf, flags_unf);
    end
    seen = 1'b0;
    repeat (TIMEOUT + 6) begin
      @(negedge sys_clk);
      if (cpu.rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_request_rsp: got rsp_valid seen=%b expected 0", seen);
    end
  endtask

  initial begin
    cpu.req_valid = 1'b0;
    cpu.req_op    = '0;
    cpu.req_rd    = '0;
    cpu.req_x1    = '0;
    cpu.req_x2    = '0;
    cpu.rsp_ready = 1'b1;
    test_reset();
    test_fadd();
    test_fabs_latency();
    test_flags();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d responses outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns");
    $fatal(1, "simulation time limit reached");
  end

endmodule
